// File: rtl/uart_digest_tx_pkg.sv
// Shared definitions for the digest UART transmitter: frame FSM encoding,
// oversample constant and the nibble-to-ASCII-hex encoder.
package uart_digest_tx_pkg;

  localparam int unsigned OS_TICKS = 16;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Uppercase hex character for one nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_digest_tx_if.sv
// Request/status handshake between the digest source and the UART transmitter.
interface uart_digest_tx_if #(
  parameter int unsigned DBIT = 160
);
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (output tx_start, tx_din, input tx_busy, tx_done_tick);
  modport slave  (input tx_start, tx_din, output tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_digest_tx_byte.sv
// Single 8N1 frame serializer. din is sampled when the start bit ends, and a
// pending start at the end of the stop bit chains the next frame with no gap.
module uart_byte_tx
  import uart_digest_tx_pkg::*;
#(
  parameter int unsigned SB_TICK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_tick,
  input  logic [7:0]  din,
  output logic        done_tick,
  output logic        tx
);

  localparam int unsigned TMAX = (SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS;
  localparam int unsigned TW   = $clog2(TMAX);

  tx_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start && s_tick) begin
          state_d = ST_START;
          tick_d  = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: if (s_tick) begin
        if (tick_q == TW'(OS_TICKS - 1)) begin
          state_d = ST_DATA;
          tick_d  = '0;
          bit_d   = '0;
          sh_d    = din;
          tx_d    = din[0];
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_DATA: if (s_tick) begin
        if (tick_q == TW'(OS_TICKS - 1)) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_STOP: if (s_tick) begin
        if (tick_q == TW'(SB_TICK - 1)) begin
          done_d = 1'b1;
          tick_d = '0;
          if (start) begin
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx        = tx_q;
  assign done_tick = done_q;

endmodule

// File: rtl/uart_digest_tx.sv
// Sends a DBIT-wide digest as back-to-back 8N1 frames, most-significant byte
// first. Define HEX_ASCII_EN to send each byte as two uppercase hex characters.
module uart_digest_tx
  import uart_digest_tx_pkg::*;
#(
  parameter int unsigned DBIT    = 160,
  parameter int unsigned SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  uart_digest_tx_if.slave  bus,
  output logic             tx
);

  localparam int unsigned NBYTES = DBIT / BYTE_W;
`ifdef HEX_ASCII_EN
  localparam int unsigned NCHAR  = 2 * NBYTES;
`else
  localparam int unsigned NCHAR  = NBYTES;
`endif
  localparam int unsigned CW     = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHAR - 1);

  logic            busy_q, busy_d;
  logic            started_q, started_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DBIT-1:0] word_q, word_d;
  logic            done_q, done_d;

  logic            frame_done;
  logic            start_c;
  logic [7:0]      byte_c;
  logic [7:0]      din_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      started_q <= 1'b0;
      cnt_q     <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      started_q <= started_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      done_q    <= done_d;
    end
  end

  // cnt_q counts finished frames; the first frame launches on the first tick
  always_comb begin
    busy_d    = busy_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    done_d    = 1'b0;
    if (!busy_q) begin
      if (bus.tx_start) begin
        busy_d    = 1'b1;
        started_d = 1'b0;
        cnt_d     = '0;
        word_d    = bus.tx_din;
      end
    end else begin
      if (!started_q && s_tick) started_d = 1'b1;
      if (frame_done) begin
        if (cnt_q == LAST) begin
          busy_d    = 1'b0;
          started_d = 1'b0;
          cnt_d     = '0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`ifdef HEX_ASCII_EN
          if (cnt_q[0]) word_d = word_q << BYTE_W;
`else
          word_d = word_q << BYTE_W;
`endif
        end
      end
    end
  end

  assign start_c = busy_q && (!started_q || (cnt_q != LAST));
  assign byte_c  = word_q[DBIT-1 -: 8];

`ifdef HEX_ASCII_EN
  assign din_c = cnt_q[0] ? nibble_to_ascii(byte_c[3:0]) : nibble_to_ascii(byte_c[7:4]);
`else
  assign din_c = byte_c;
`endif

  uart_byte_tx #(
    .SB_TICK (SB_TICK)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (start_c),
    .s_tick    (s_tick),
    .din       (din_c),
    .done_tick (frame_done),
    .tx        (tx)
  );

  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule
